// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: rx_done edge capture, show-ahead read, sticky overflow.
// Define UART_RX_FIFO_OVERWRITE_EN to make a write into a full FIFO discard the oldest byte instead of the new one.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  rx_done_q;

    logic wr_pulse, rd_fire, ovf_set, mem_we, rd_adv, full_w;

    assign full_w = (count_q == FULL_CNT);

    always_comb begin
        wr_pulse = rx_done & ~rx_done_q;
        rd_fire  = rd_en & (count_q != '0);
        ovf_set  = wr_pulse & full_w & ~rd_fire;
`ifdef UART_RX_FIFO_OVERWRITE_EN
        // Overwrite: the write always lands; a blocked write pushes the head forward.
        mem_we   = wr_pulse;
        rd_adv   = rd_fire | ovf_set;
`else
        mem_we   = wr_pulse & ~ovf_set;
        rd_adv   = rd_fire;
`endif
        wr_ptr_d = mem_we ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_adv ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (mem_we && !rd_adv) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_adv && !mem_we) begin
            count_d = count_q - CNT_ONE;
        end
        // A new overflow outranks a concurrent clear.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // Held high so a done level spanning reset is not seen as a fresh byte.
            rx_done_q  <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rx_done_q  <= rx_done;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign full     = full_w;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: per-cycle vector table plus hand sequences for fill/drain, overflow and reset.
// Expectations follow UART_RX_FIFO_OVERWRITE_EN when defined for the build.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       rd;
        logic       clr;
        logic [4:0] cnt;
        logic [7:0] head;
        logic       ovf;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic d, logic [7:0] dat, logic r, logic c,
                                logic [4:0] n, logic [7:0] h, logic o);
        vec_t v;
        v.done = d; v.data = dat; v.rd = r; v.clr = c;
        v.cnt = n; v.head = h; v.ovf = o;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_done = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; rx_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic write_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic fill_0_to_f();
        for (int i = 0; i < 16; i++) write_byte(8'(i));
    endtask

    // Pops n bytes back-to-back, comparing each head against exp_q in order.
    task automatic pop_all(input string name, input logic [7:0] exp_q[$]);
        rd_en = 1'b1;
        foreach (exp_q[i]) begin
            chk($sformatf("%s[%0d]", name, i), {24'h0, rd_data}, {24'h0, exp_q[i]});
            tick();
        end
        rd_en = 1'b0;
        chk({name, "_empty"}, {31'h0, rd_valid}, 32'h0);
        chk({name, "_cnt0"}, {27'h0, count}, 32'h0);
    endtask

    initial begin
        logic [7:0] q[$];

        vecs[0]  = mk(1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 8'h41, 1'b0);
        vecs[1]  = mk(1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 8'h41, 1'b0);
        vecs[2]  = mk(1'b1, 8'h42, 1'b0, 1'b0, 5'd1, 8'h41, 1'b0);
        vecs[3]  = mk(1'b0, 8'h42, 1'b0, 1'b0, 5'd1, 8'h41, 1'b0);
        vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
        vecs[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
        vecs[6]  = mk(1'b1, 8'h7E, 1'b1, 1'b0, 5'd1, 8'h7E, 1'b0);
        vecs[7]  = mk(1'b1, 8'h7E, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
        vecs[8]  = mk(1'b0, 8'h33, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
        vecs[9]  = mk(1'b1, 8'h33, 1'b0, 1'b0, 5'd1, 8'h33, 1'b0);
        vecs[10] = mk(1'b0, 8'h33, 1'b0, 1'b1, 5'd1, 8'h33, 1'b0);
        vecs[11] = mk(1'b1, 8'h44, 1'b0, 1'b0, 5'd2, 8'h33, 1'b0);
        vecs[12] = mk(1'b1, 8'h44, 1'b1, 1'b0, 5'd1, 8'h44, 1'b0);
        vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0);

        // Reset state
        do_reset();
        chk("rst_count", {27'h0, count}, 32'h0);
        chk("rst_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);

        // Per-cycle vector table
        foreach (vecs[i]) begin
            rx_done = vecs[i].done; rx_data = vecs[i].data;
            rd_en = vecs[i].rd; ovf_clr = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_count", i), {27'h0, count}, {27'h0, vecs[i].cnt});
            chk($sformatf("vec%0d_valid", i), {31'h0, rd_valid}, {31'h0, (vecs[i].cnt != 5'd0)});
            chk($sformatf("vec%0d_ovf", i), {31'h0, overflow}, {31'h0, vecs[i].ovf});
            if (vecs[i].cnt != 5'd0)
                chk($sformatf("vec%0d_head", i), {24'h0, rd_data}, {24'h0, vecs[i].head});
        end
        rd_en = 1'b0; rx_done = 1'b0;

        // Long rx_done level yields exactly one entry
        do_reset();
        rx_data = 8'h41; rx_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("hold%0d_count", i), {27'h0, count}, 32'h1);
        end
        chk("hold_head", {24'h0, rd_data}, 32'h41);
        rx_done = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("hold_pop_count", {27'h0, count}, 32'h0);
        chk("hold_pop_valid", {31'h0, rd_valid}, 32'h0);

        // Fill to 16 then drain back-to-back, twice to exercise pointer wrap
        for (int pass = 0; pass < 2; pass++) begin
            fill_0_to_f();
            chk("fill_full", {31'h0, full}, 32'h1);
            chk("fill_count", {27'h0, count}, 32'd16);
            chk("fill_ovf", {31'h0, overflow}, 32'h0);
            q.delete();
            for (int i = 0; i < 16; i++) q.push_back(8'(i));
            pop_all($sformatf("drain%0d", pass), q);
        end
        write_byte(8'h99);
        chk("wrap_head", {24'h0, rd_data}, 32'h99);
        chk("wrap_count", {27'h0, count}, 32'h1);

        // 17th byte into a full FIFO
        do_reset();
        fill_0_to_f();
        write_byte(8'hAA);
        chk("ovf_set", {31'h0, overflow}, 32'h1);
        chk("ovf_count", {27'h0, count}, 32'd16);
        q.delete();
`ifdef UART_RX_FIFO_OVERWRITE_EN
        chk("ovf_head", {24'h0, rd_data}, 32'h01);
        for (int i = 1; i < 16; i++) q.push_back(8'(i));
        q.push_back(8'hAA);
`else
        chk("ovf_head", {24'h0, rd_data}, 32'h00);
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
`endif
        pop_all("ovf_drain", q);
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);

        // Simultaneous write and read while full
        do_reset();
        fill_0_to_f();
        rx_data = 8'hBB; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("wr_rd_full_count", {27'h0, count}, 32'd16);
        chk("wr_rd_full_ovf", {31'h0, overflow}, 32'h0);
        chk("wr_rd_full_head", {24'h0, rd_data}, 32'h01);
        rx_done = 1'b0;
        tick();

        // Clear colliding with a new overflow: set wins, then clear alone
        rx_data = 8'hCC; rx_done = 1'b1; ovf_clr = 1'b1;
        tick();
        chk("clr_vs_set", {31'h0, overflow}, 32'h1);
        rx_done = 1'b0;
        tick();
        ovf_clr = 1'b0;
        chk("clr_alone", {31'h0, overflow}, 32'h0);
        q.delete();
`ifdef UART_RX_FIFO_OVERWRITE_EN
        for (int i = 2; i < 16; i++) q.push_back(8'(i));
        q.push_back(8'hBB);
        q.push_back(8'hCC);
`else
        for (int i = 1; i < 16; i++) q.push_back(8'(i));
        q.push_back(8'hBB);
`endif
        pop_all("wr_rd_drain", q);

        // Reset with 5 entries stored and rx_done held high across reset
        do_reset();
        for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i));
        chk("pre_rst_count", {27'h0, count}, 32'd5);
        rx_data = 8'h77; rx_done = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("post_rst_count", {27'h0, count}, 32'h0);
        chk("post_rst_valid", {31'h0, rd_valid}, 32'h0);
        rx_done = 1'b0;
        tick();
        write_byte(8'h55);
        chk("post_rst_new_count", {27'h0, count}, 32'h1);
        chk("post_rst_new_head", {24'h0, rd_data}, 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
